// File: rtl/dmem_rmw_ctrl.sv
// Data-memory access sequencer: one load/store at a time, sub-word stores
// performed as read-modify-write, misaligned/unsupported requests answered
// with an error response without touching memory.
module dmem_rmw_ctrl #(
  parameter int unsigned BIG_ENDIAN = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rd,
  output logic        mem_we,
  output logic [31:0] mem_wd
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_WRITE,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [1:0]  byte_lane;
  logic        half_lane;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_v;
  logic [31:0] merged;

  // True when the opcode is supported and the address meets its alignment.
  function automatic logic req_ok(input logic [5:0] o, input logic [1:0] a);
    case (o)
      OP_LB, OP_LBU, OP_SB: return 1'b1;
      OP_LH, OP_LHU, OP_SH: return ~a[0];
      OP_LW, OP_SW:         return (a == 2'b00);
      default:              return 1'b0;
    endcase
  endfunction

  // Lane selection, load extraction and store merge from the latched request.
  always_comb begin
    byte_lane = (BIG_ENDIAN != 0) ? ~addr_q[1:0] : addr_q[1:0];
    half_lane = (BIG_ENDIAN != 0) ? ~addr_q[1]   : addr_q[1];
    byte_v    = mem_rd[{byte_lane, 3'b000} +: 8];
    half_v    = mem_rd[{half_lane, 4'b0000} +: 16];

    case (op_q)
      OP_LB:   load_v = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_v = {24'h000000, byte_v};
      OP_LH:   load_v = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_v = {16'h0000, half_v};
      default: load_v = mem_rd;
    endcase

    merged = mem_rd;
    if (op_q == OP_SB) begin
      merged[{byte_lane, 3'b000} +: 8] = wd_q[7:0];
    end else begin
      merged[{half_lane, 4'b0000} +: 16] = wd_q[15:0];
    end
  end

  // Next-state and datapath register updates.
  // wd_q holds the raw store data from accept and is overwritten with the
  // merged word in CAPT, so mem_wd is simply wd_q in WRITE for every store.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d   = op;
          addr_d = addr;
          wd_d   = wdata;
          err_d  = ~req_ok(op, addr[1:0]);
          if (!req_ok(op, addr[1:0])) begin
            state_d = S_RESP;
          end else if (op == OP_SW) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: state_d = S_CAPT;
      S_CAPT: begin
        if (op_q[3]) begin
          wd_d    = merged;
          state_d = S_WRITE;
        end else begin
          rdata_d = load_v;
          state_d = S_RESP;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decoded from state so strobes drop as soon as reset asserts.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_err   = (state_q == S_RESP) & err_q;
    rdata      = rdata_q;
    mem_addr   = {addr_q[31:2], 2'b00};
    mem_re     = (state_q == S_READ);
    mem_we     = (state_q == S_WRITE);
    mem_wd     = wd_q;
  end

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Bench for dmem_rmw_ctrl: table of directed requests against a small
// synchronous-read memory, plus reset-value and reset-mid-RMW sequences.
module tb_dmem_rmw_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rd;
  logic        mem_we;
  logic [31:0] mem_wd;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];

  dmem_rmw_ctrl #(.BIG_ENDIAN(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .rdata      (rdata),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_rd     (mem_rd),
    .mem_we     (mem_we),
    .mem_wd     (mem_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory model: data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] = mem_wd;
    if (mem_re) mem_rd <= mem[mem_addr[9:2]];
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic        e_err;
    int          e_lat;
    int          e_re;
    int          e_we;
    logic [31:0] e_wd;
    logic [31:0] e_mem;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] o, input logic [31:0] a, input logic [31:0] w,
                              input logic [31:0] ini, input logic er, input int lat,
                              input int re, input int we, input logic [31:0] wd,
                              input logic [31:0] m, input logic [31:0] rd);
    vec_t t;
    t.op = o; t.addr = a; t.wdata = w; t.init = ini; t.e_err = er; t.e_lat = lat;
    t.e_re = re; t.e_we = we; t.e_wd = wd; t.e_mem = m; t.e_rdata = rd;
    return t;
  endfunction

  // Results of the most recent run_req.
  int          r_lat, r_re, r_we, r_re_cnt, r_we_cnt;
  logic        r_err, r_both, r_ready_before, r_ready_after, r_valid_after;
  logic [31:0] r_wd, r_re_addr, r_we_addr, r_rdata;

  // Issue one request, scramble inputs after accept, observe up to 12 cycles.
  task automatic run_req(input logic [5:0] o, input logic [31:0] a, input logic [31:0] w);
    r_lat = -1; r_re = 0; r_we = 0; r_re_cnt = 0; r_we_cnt = 0;
    r_err = 1'bx; r_both = 1'b0; r_wd = '0; r_re_addr = '0; r_we_addr = '0; r_rdata = '0;
    @(negedge clk);
    r_ready_before = req_ready;
    req_valid = 1'b1; op = o; addr = a; wdata = w;
    @(posedge clk);
    #1;
    req_valid = 1'b0; op = 6'b100011; addr = 32'h0000_03FC; wdata = 32'h0BAD_0BAD;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (mem_re && mem_we) r_both = 1'b1;
      if (mem_re) begin r_re_cnt++; r_re = cyc; r_re_addr = mem_addr; end
      if (mem_we) begin r_we_cnt++; r_we = cyc; r_we_addr = mem_addr; r_wd = mem_wd; end
      if (resp_valid) begin
        r_lat = cyc; r_err = resp_err; r_rdata = rdata;
        break;
      end
    end
    @(negedge clk);
    r_ready_after = req_ready;
    r_valid_after = resp_valid;
  endtask

  localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011, LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101, SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;

  vec_t vecs [17];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem_rd = '0;
    reset = 1'b0; req_valid = 1'b0; op = '0; addr = '0; wdata = '0;

    vecs[0]  = mk(SB,  32'h101, 32'hFFFFFFAB, 32'h11223344, 0, 4, 1, 3, 32'h1122AB44, 32'h1122AB44, 32'h0);
    vecs[1]  = mk(LB,  32'h103, 32'h0,        32'h11223344, 0, 3, 1, 0, 32'h0, 32'h11223344, 32'h00000011);
    vecs[2]  = mk(LB,  32'h103, 32'h0,        32'h80FF7F00, 0, 3, 1, 0, 32'h0, 32'h80FF7F00, 32'hFFFFFF80);
    vecs[3]  = mk(LBU, 32'h103, 32'h0,        32'h80FF7F00, 0, 3, 1, 0, 32'h0, 32'h80FF7F00, 32'h00000080);
    vecs[4]  = mk(LH,  32'h102, 32'h0,        32'h80FF7F00, 0, 3, 1, 0, 32'h0, 32'h80FF7F00, 32'hFFFF80FF);
    vecs[5]  = mk(LHU, 32'h100, 32'h0,        32'h80FF7F00, 0, 3, 1, 0, 32'h0, 32'h80FF7F00, 32'h00007F00);
    vecs[6]  = mk(SW,  32'h100, 32'hDEADBEEF, 32'h11223344, 0, 2, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00007F00);
    vecs[7]  = mk(SH,  32'h101, 32'h00005566, 32'h11223344, 1, 1, 0, 0, 32'h0, 32'h11223344, 32'h00007F00);
    vecs[8]  = mk(LW,  32'h102, 32'h0,        32'h11223344, 1, 1, 0, 0, 32'h0, 32'h11223344, 32'h00007F00);
    vecs[9]  = mk(6'b000000, 32'h100, 32'h0,  32'h11223344, 1, 1, 0, 0, 32'h0, 32'h11223344, 32'h00007F00);
    vecs[10] = mk(LW,  32'h100, 32'h0,        32'hCAFEF00D, 0, 3, 1, 0, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D);
    vecs[11] = mk(SH,  32'h102, 32'h12345566, 32'h11223344, 0, 4, 1, 3, 32'h55663344, 32'h55663344, 32'hCAFEF00D);
    vecs[12] = mk(SB,  32'h103, 32'h000000EE, 32'h11223344, 0, 4, 1, 3, 32'hEE223344, 32'hEE223344, 32'hCAFEF00D);
    vecs[13] = mk(LH,  32'h100, 32'h0,        32'h11228001, 0, 3, 1, 0, 32'h0, 32'h11228001, 32'hFFFF8001);
    vecs[14] = mk(LBU, 32'h100, 32'h0,        32'h112233F0, 0, 3, 1, 0, 32'h0, 32'h112233F0, 32'h000000F0);
    vecs[15] = mk(6'b100010, 32'h100, 32'h0,  32'h11223344, 1, 1, 0, 0, 32'h0, 32'h11223344, 32'h000000F0);
    vecs[16] = mk(SW,  32'h102, 32'h01020304, 32'h11223344, 1, 1, 0, 0, 32'h0, 32'h11223344, 32'h000000F0);

    // Reset values while reset is held low.
    repeat (2) @(negedge clk);
    check("rst_req_ready",  {31'b0, req_ready},  32'h1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_err",   {31'b0, resp_err},   32'h0);
    check("rst_rdata",      rdata,               32'h0);
    check("rst_mem_re",     {31'b0, mem_re},     32'h0);
    check("rst_mem_we",     {31'b0, mem_we},     32'h0);
    check("rst_mem_addr",   mem_addr,            32'h0);
    check("rst_mem_wd",     mem_wd,              32'h0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      mem[64] = vecs[i].init;
      run_req(vecs[i].op, vecs[i].addr, vecs[i].wdata);
      check($sformatf("v%0d_ready", i), {31'b0, r_ready_before}, 32'h1);
      check($sformatf("v%0d_lat", i),   r_lat,                   vecs[i].e_lat);
      check($sformatf("v%0d_err", i),   {31'b0, r_err},          {31'b0, vecs[i].e_err});
      check($sformatf("v%0d_re_cyc", i), r_re,                   vecs[i].e_re);
      check($sformatf("v%0d_we_cyc", i), r_we,                   vecs[i].e_we);
      check($sformatf("v%0d_re_cnt", i), r_re_cnt,               (vecs[i].e_re != 0) ? 1 : 0);
      check($sformatf("v%0d_we_cnt", i), r_we_cnt,               (vecs[i].e_we != 0) ? 1 : 0);
      check($sformatf("v%0d_re_we_overlap", i), {31'b0, r_both}, 32'h0);
      if (vecs[i].e_re != 0)
        check($sformatf("v%0d_re_addr", i), r_re_addr, {vecs[i].addr[31:2], 2'b00});
      if (vecs[i].e_we != 0) begin
        check($sformatf("v%0d_we_addr", i), r_we_addr, {vecs[i].addr[31:2], 2'b00});
        check($sformatf("v%0d_mem_wd", i),  r_wd,      vecs[i].e_wd);
      end
      check($sformatf("v%0d_mem_word", i), mem[64], vecs[i].e_mem);
      check($sformatf("v%0d_rdata", i),    r_rdata, vecs[i].e_rdata);
      check($sformatf("v%0d_pulse", i),    {31'b0, r_valid_after}, 32'h0);
      check($sformatf("v%0d_ready_after", i), {31'b0, r_ready_after}, 32'h1);
    end

    // Reset asserted during CAPT of an sh read-modify-write.
    mem[64] = 32'h11223344;
    @(negedge clk);
    req_valid = 1'b1; op = SH; addr = 32'h102; wdata = 32'h00005566;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_read_re", {31'b0, mem_re}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_we",    {31'b0, mem_we},    32'h0);
    check("mid_rst_re",    {31'b0, mem_re},    32'h0);
    check("mid_rst_ready", {31'b0, req_ready}, 32'h1);
    check("mid_rst_rdata", rdata,              32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    begin
      int late = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (mem_we || resp_valid || mem_re) late++;
      end
      check("mid_no_late_activity", late, 0);
    end
    check("mid_ready_after", {31'b0, req_ready}, 32'h1);
    check("mid_mem_word",    mem[64],            32'h11223344);
    run_req(LW, 32'h100, 32'h0);
    check("mid_lw_lat",   r_lat,           3);
    check("mid_lw_err",   {31'b0, r_err},  32'h0);
    check("mid_lw_rdata", r_rdata,         32'h11223344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
